// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator, its ones-run tracker and benches.
// Holds the FSM state encoding and the detector threshold.
package serial_pattern_gen_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Number of consecutive ones after which the reference detector asserts.
    localparam logic [1:0] RUN_MAX = 2'd3;

endpackage

// File: rtl/ones_run_tracker.sv
// Tracks consecutive ones on a serial line and produces the registered Moore output of a
// same-clock three-or-more-ones detector.
module ones_run_tracker
    import serial_pattern_gen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic exp_y
);

    logic [1:0] run_q;
    logic [1:0] run_d;

    // Saturating run length; any sampled zero restarts the count.
    always_comb begin
        run_d = 2'd0;
        if (din) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 2'd0;
            exp_y <= 1'b0;
        end else begin
            run_q <= run_d;
            exp_y <= (run_d == RUN_MAX);
        end
    end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial stimulus transmitter: shifts a latched pattern word out MSB-first, repeated with
// zero gap bits between frames, and tracks the expected three-ones detector output.
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [REP_W-1:0] reps,
    output logic             x_out,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             exp_y
);

    localparam int unsigned BitCntW = $clog2(WIDTH);
    localparam int unsigned GapCntW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BitCntW-1:0] BitLast = BitCntW'(WIDTH - 1);
    localparam logic [GapCntW-1:0] GapLoad = GapCntW'((GAP > 0) ? GAP - 1 : 0);

    state_e             state_q;
    logic [WIDTH-1:0]   word_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [BitCntW-1:0] bit_cnt_q;
    logic [GapCntW-1:0] gap_cnt_q;
    logic [REP_W-1:0]   reps_left_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            reps_left_q <= '0;
            x_out       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    x_out <= 1'b0;
                    if (start) begin
                        word_q      <= data;
                        shreg_q     <= data;
                        reps_left_q <= reps;
                        bit_cnt_q   <= BitLast;
                        x_out       <= data[WIDTH-1];
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    if (bit_cnt_q != '0) begin
                        shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                        x_out     <= shreg_q[WIDTH-2];
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end else if (reps_left_q == '0) begin
                        x_out   <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        reps_left_q <= reps_left_q - 1'b1;
                        shreg_q     <= word_q;
                        if (GAP > 0) begin
                            x_out     <= 1'b0;
                            gap_cnt_q <= GapLoad;
                            state_q   <= StGap;
                        end else begin
                            // Back-to-back frames: next MSB follows with no idle bit.
                            x_out     <= word_q[WIDTH-1];
                            bit_cnt_q <= BitLast;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == '0) begin
                        x_out     <= word_q[WIDTH-1];
                        bit_cnt_q <= BitLast;
                        state_q   <= StShift;
                    end else begin
                        x_out     <= 1'b0;
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    x_out   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    x_out   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StShift) || (state_q == StGap);
    assign done  = (state_q == StDone);

    ones_run_tracker u_tracker (
        .clk   (clk),
        .rst   (rst),
        .din   (x_out),
        .exp_y (exp_y)
    );

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Randomized self-checking bench for serial_pattern_gen against a frame-level stream model.
module tb_serial_pattern_gen;
    import serial_pattern_gen_pkg::*;

    localparam int WIDTH = 8;
    localparam int REP_W = 4;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data;
    logic [REP_W-1:0] reps;
    logic             x_out;
    logic             ready;
    logic             busy;
    logic             done;
    logic             exp_y;

    int n_checks = 0;
    int n_fail   = 0;

    bit xhist[$];

    serial_pattern_gen #(
        .WIDTH (WIDTH),
        .REP_W (REP_W),
        .GAP   (GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .reps  (reps),
        .x_out (x_out),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .exp_y (exp_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Detector reference: high when the last RUN_MAX line values seen at clock edges were 1.
    function automatic bit model_exp_y();
        if (xhist.size() < int'(RUN_MAX)) return 1'b0;
        for (int i = 1; i <= int'(RUN_MAX); i++) begin
            if (!xhist[xhist.size() - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_cycle(input bit x, input bit bsy, input bit dn, input bit rdy);
        check("x_out", x_out, x);
        check("busy", busy, bsy);
        check("done", done, dn);
        check("ready", ready, rdy);
        check("exp_y", exp_y, model_exp_y());
        xhist.push_back(x);
        if (xhist.size() > 8) void'(xhist.pop_front());
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Sends one transaction and checks every cycle through done and the following idle cycle.
    // With hold set, start stays high with scrambled data/reps for the whole transfer.
    task automatic send(input logic [WIDTH-1:0] d, input int r, input bit hold);
        bit stream[$];
        for (int f = 0; f <= r; f++) begin
            if (f > 0) for (int g = 0; g < GAP; g++) stream.push_back(1'b0);
            for (int i = WIDTH - 1; i >= 0; i--) stream.push_back(d[i]);
        end
        start = 1'b1;
        data  = d;
        reps  = REP_W'(r);
        foreach (stream[c]) begin
            @(negedge clk);
            if (hold) begin
                data = WIDTH'($urandom);
                reps = REP_W'($urandom);
            end else begin
                start = 1'b0;
            end
            check_cycle(stream[c], 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        check_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        reps  = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_x_out", x_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_exp_y", exp_y, 1'b0);
        check("rst_ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        check_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        send(8'hB3, 0, 1'b0);
        send(8'hFF, 0, 1'b0);
        send(8'hF0, 1, 1'b0);
        send(8'h3C, 2, 1'b1);
        send(8'h81, 1, 1'b0);
        send(8'h6D, 15, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'hFF, 2, 1'b0);
        idle(1);

        repeat (20) begin
            send(WIDTH'($urandom), int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        // Abandon a multi-frame transfer with an asynchronous reset while exp_y is high.
        start = 1'b1;
        data  = 8'hFF;
        reps  = 4'd3;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
            check_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_x_out", x_out, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_exp_y", exp_y, 1'b0);
        check("mid_rst_ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        xhist.delete();
        check_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        send(8'hA5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
